debug_monitor: RTL and testbench

- UART-driven debug controller for the RangerRisc softcore.
- Decodes single-byte commands from the UART receiver and manages the CPU clock and reset: single step, N-cycle burst, and reset hold.
- Streams a parametrised snapshot of CPU debug signals back through the UART transmitter.
- Sits between UARTRx/UARTTx and RangerRiscProcessor in the board top; replaces the hand-coded per-byte status case with a generic word/byte serializer.

---
 rtl/debug_monitor_if.sv | 26 ++
 rtl/debug_monitor.sv | 242 ++++++++++++++++++++++++
 tb/tb_debug_monitor.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_monitor_if.sv
// UART byte link between debug_monitor (master side) and the UART rx/tx pair (slave side).
// rx_complete_i and tx_start_o are single-cycle strobes that qualify their byte; tx_complete_i
// is the transmitter's one-cycle "ready for next byte" reply and is only honoured while waiting.
interface debug_monitor_if;
   logic [7:0] rx_byte_i;
   logic       rx_complete_i;
   logic [7:0] tx_byte_o;
   logic       tx_start_o;
   logic       tx_complete_i;

   modport master (
      input  rx_byte_i,
      input  rx_complete_i,
      input  tx_complete_i,
      output tx_byte_o,
      output tx_start_o
   );

   modport slave (
      output rx_byte_i,
      output rx_complete_i,
      output tx_complete_i,
      input  tx_byte_o,
      input  tx_start_o
   );
endinterface

// File: rtl/debug_monitor.sv
// UART debug controller for RangerRisc: CPU clock/reset control, burst stepping and status dump.
// Define DBG_CHECKSUM_EN to append an XOR checksum byte to every status dump.
module debug_monitor #(
   parameter int STATUS_WORDS = 8,
   parameter int WORD_WIDTH   = 32,
   parameter int RESET_HOLD   = 16,
   parameter int STEP_BURST   = 256,
   parameter int HALF_DIV     = 1
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   debug_monitor_if.master                      uart,
   input  logic [STATUS_WORDS*WORD_WIDTH-1:0]   status_i,
   input  logic                                 halt_i,
   output logic                                 cpu_clk_o,
   output logic                                 cpu_reset_n_o,
   output logic [7:0]                           last_cmd_o,
   output logic                                 busy_o,
   output logic                                 rx_drop_o,
   output logic [3:0]                           state_o
);
   localparam int NBYTES = STATUS_WORDS * WORD_WIDTH / 8;
`ifdef DBG_CHECKSUM_EN
   localparam int DUMP_LEN = NBYTES + 1;
`else
   localparam int DUMP_LEN = NBYTES;
`endif
   localparam int IDX_W  = (DUMP_LEN > 1) ? $clog2(DUMP_LEN) : 1;
   localparam int HOLD_W = $clog2(RESET_HOLD);
   localparam int EDGE_W = $clog2(STEP_BURST + 1);
   localparam int DIV_W  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DUMP_LEN - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
   localparam logic [EDGE_W-1:0] EDGE_ALL  = EDGE_W'(STEP_BURST);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(HALF_DIV - 1);

   localparam logic [3:0] BOOT_HOLD = 4'd0;
   localparam logic [3:0] IDLE      = 4'd1;
   localparam logic [3:0] RST_HOLD  = 4'd2;
   localparam logic [3:0] PULSE     = 4'd3;
   localparam logic [3:0] BURST     = 4'd4;
   localparam logic [3:0] ACK_SEND  = 4'd5;
   localparam logic [3:0] ACK_WAIT  = 4'd6;
   localparam logic [3:0] STAT_LOAD = 4'd7;
   localparam logic [3:0] STAT_SEND = 4'd8;
   localparam logic [3:0] STAT_WAIT = 4'd9;

   logic [3:0]        state_q;
   logic [HOLD_W-1:0] hold_cnt;
   logic [EDGE_W-1:0] edge_cnt;
   logic [DIV_W-1:0]  div_cnt;
   logic [IDX_W-1:0]  byte_idx;
   logic [1:0]        ack_idx;
   logic [7:0]        ack_c1, ack_c2, ack_byte, snap_byte;
   logic [7:0]        tx_byte_q, last_cmd_q;
   logic              tx_start_q, cpu_clk_q, cpu_rst_n_q, rx_drop_q;
   logic [7:0]        snap_q [NBYTES];

   // Snapshot is pure data; it is only read after a STAT_LOAD cycle has filled it.
   always_ff @(posedge clk_i) begin
      if (state_q == STAT_LOAD) begin
         for (int b = 0; b < NBYTES; b++) snap_q[b] <= status_i[b*8 +: 8];
      end
   end

   always_comb begin
      snap_byte = 8'h00;
      for (int b = 0; b < NBYTES; b++) begin
         if (byte_idx == IDX_W'(b)) snap_byte = snap_q[b];
      end
`ifdef DBG_CHECKSUM_EN
      if (byte_idx == IDX_W'(NBYTES)) begin
         for (int b = 0; b < NBYTES; b++) snap_byte = snap_byte ^ snap_q[b];
      end
`endif
   end

   always_comb begin
      case (ack_idx)
         2'd0:    ack_byte = ack_c1;
         2'd1:    ack_byte = ack_c2;
         2'd2:    ack_byte = 8'h0D;
         default: ack_byte = 8'h0A;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= BOOT_HOLD;
         hold_cnt    <= '0;
         edge_cnt    <= '0;
         div_cnt     <= '0;
         byte_idx    <= '0;
         ack_idx     <= 2'd0;
         ack_c1      <= 8'h00;
         ack_c2      <= 8'h00;
         tx_byte_q   <= 8'h00;
         tx_start_q  <= 1'b0;
         cpu_clk_q   <= 1'b0;
         cpu_rst_n_q <= 1'b0;
         last_cmd_q  <= 8'h00;
         rx_drop_q   <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         if (uart.rx_complete_i && state_q != IDLE) rx_drop_q <= 1'b1;
         case (state_q)
            BOOT_HOLD, RST_HOLD: begin
               cpu_clk_q <= ~cpu_clk_q;
               if (hold_cnt == HOLD_LAST) begin
                  hold_cnt    <= '0;
                  cpu_rst_n_q <= 1'b1;
                  cpu_clk_q   <= 1'b0;
                  if (state_q == RST_HOLD) begin
                     ack_c1  <= 8'h52;
                     ack_c2  <= 8'h73;
                     ack_idx <= 2'd0;
                     state_q <= ACK_SEND;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            IDLE: begin
               if (uart.rx_complete_i) begin
                  last_cmd_q <= uart.rx_byte_i;
                  ack_idx    <= 2'd0;
                  state_q    <= ACK_SEND;
                  case (uart.rx_byte_i)
                     8'h72: begin
                        state_q     <= RST_HOLD;
                        hold_cnt    <= '0;
                        cpu_rst_n_q <= 1'b0;
                        cpu_clk_q   <= 1'b0;
                     end
                     8'h65: begin
                        cpu_rst_n_q <= ~cpu_rst_n_q;
                        ack_c1 <= 8'h52; ack_c2 <= 8'h61;
                     end
                     8'h7A: begin
                        cpu_clk_q <= 1'b1;
                        ack_c1 <= 8'h43; ack_c2 <= 8'h72;
                     end
                     8'h78: begin
                        cpu_clk_q <= 1'b0;
                        ack_c1 <= 8'h43; ack_c2 <= 8'h66;
                     end
                     8'h63: begin
                        cpu_clk_q <= 1'b1;
                        ack_c1 <= 8'h43; ack_c2 <= 8'h74;
                        state_q <= PULSE;
                     end
                     8'h6E: begin
                        cpu_clk_q <= 1'b0;
                        div_cnt   <= '0;
                        edge_cnt  <= '0;
                        state_q   <= BURST;
                     end
                     8'h73: state_q <= STAT_LOAD;
                     default: begin
                        ack_c1 <= 8'h4F; ack_c2 <= 8'h6B;
                     end
                  endcase
               end
            end
            PULSE: begin
               cpu_clk_q <= 1'b0;
               state_q   <= ACK_SEND;
            end
            // halt_i is only honoured at the end of a low phase, so cpu_clk_o always ends low.
            BURST: begin
               if (div_cnt != DIV_LAST) begin
                  div_cnt <= div_cnt + 1'b1;
               end else begin
                  div_cnt <= '0;
                  if (cpu_clk_q) begin
                     cpu_clk_q <= 1'b0;
                     if (edge_cnt == EDGE_ALL) begin
                        ack_c1 <= 8'h43; ack_c2 <= 8'h6E;
                        ack_idx <= 2'd0;
                        state_q <= ACK_SEND;
                     end
                  end else if (halt_i) begin
                     ack_c1 <= 8'h43; ack_c2 <= 8'h68;
                     ack_idx <= 2'd0;
                     state_q <= ACK_SEND;
                  end else begin
                     cpu_clk_q <= 1'b1;
                     edge_cnt  <= edge_cnt + 1'b1;
                  end
               end
            end
            ACK_SEND: begin
               tx_byte_q  <= ack_byte;
               tx_start_q <= 1'b1;
               state_q    <= ACK_WAIT;
            end
            ACK_WAIT: begin
               if (uart.tx_complete_i) begin
                  if (ack_idx == 2'd3) begin
                     state_q <= IDLE;
                  end else begin
                     ack_idx <= ack_idx + 1'b1;
                     state_q <= ACK_SEND;
                  end
               end
            end
            STAT_LOAD: begin
               byte_idx <= '0;
               state_q  <= STAT_SEND;
            end
            STAT_SEND: begin
               tx_byte_q  <= snap_byte;
               tx_start_q <= 1'b1;
               state_q    <= STAT_WAIT;
            end
            STAT_WAIT: begin
               if (uart.tx_complete_i) begin
                  if (byte_idx == IDX_LAST) begin
                     state_q <= IDLE;
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                     state_q  <= STAT_SEND;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign uart.tx_byte_o  = tx_byte_q;
   assign uart.tx_start_o = tx_start_q;
   assign cpu_clk_o       = cpu_clk_q;
   assign cpu_reset_n_o   = cpu_rst_n_q;
   assign last_cmd_o      = last_cmd_q;
   assign rx_drop_o       = rx_drop_q;
   assign busy_o          = (state_q != IDLE);
   assign state_o         = state_q;
endmodule

// File: tb/tb_debug_monitor.sv
// Directed bench for debug_monitor: boot hold, commands, burst/halt, status dump, drop and abort.
module tb_debug_monitor;
   localparam int SW = 2;
   localparam int WW = 32;

   logic           clk_i = 1'b0;
   logic           reset_i = 1'b1;
   logic [SW*WW-1:0] status_i = '0;
   logic           halt_i = 1'b0;
   logic           cpu_clk_o, cpu_reset_n_o, busy_o, rx_drop_o;
   logic [7:0]     last_cmd_o;
   logic [3:0]     state_o;

   debug_monitor_if uart ();

   debug_monitor #(
      .STATUS_WORDS(SW), .WORD_WIDTH(WW), .RESET_HOLD(16), .STEP_BURST(256), .HALF_DIV(1)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i), .uart(uart.master), .status_i(status_i),
      .halt_i(halt_i), .cpu_clk_o(cpu_clk_o), .cpu_reset_n_o(cpu_reset_n_o),
      .last_cmd_o(last_cmd_o), .busy_o(busy_o), .rx_drop_o(rx_drop_o), .state_o(state_o)
   );

   // clock / reset-time defaults
   always #5 clk_i = ~clk_i;

   initial begin
      uart.rx_byte_i     = 8'h00;
      uart.rx_complete_i = 1'b0;
      uart.tx_complete_i = 1'b0;
   end

   int  n_checks = 0;
   int  n_fail   = 0;
   logic [7:0] exp_q[$];

   // background monitors: cpu_clk edges, burst spacing, tx_start pulses
   int  edge_cnt = 0;
   int  spacing_err = 0;
   int  tx_start_cnt = 0;
   bit  burst_mon = 0;
   bit  prev_burst = 0;
   time last_t = 0;

   always @(posedge cpu_clk_o) begin
      if (burst_mon && prev_burst && (($time - last_t) != 20)) spacing_err++;
      prev_burst = burst_mon;
      last_t = $time;
      edge_cnt++;
   end

   always @(negedge clk_i) if (uart.tx_start_o === 1'b1) tx_start_cnt++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic send_rx(input logic [7:0] b);
      uart.rx_byte_i = b;
      uart.rx_complete_i = 1'b1;
      @(negedge clk_i);
      uart.rx_complete_i = 1'b0;
   endtask

   task automatic push_ack(input logic [7:0] c1, input logic [7:0] c2);
      exp_q.push_back(c1);
      exp_q.push_back(c2);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   // UART transmitter model: accept each byte, hold off, then strobe tx_complete_i
   task automatic recv_bytes(input string name, input int n);
      logic [7:0] exp;
      int t;
      bit early;
      for (int i = 0; i < n; i++) begin
         t = 0;
         while (uart.tx_start_o !== 1'b1 && t < 2000) begin
            @(negedge clk_i);
            t++;
         end
         n_checks++;
         if (t >= 2000) begin
            n_fail++;
            $display("FAIL %s timeout: byte %0d never started, required tx_start_o=1", name, i);
            exp_q.delete();
            return;
         end
         exp = exp_q.pop_front();
         if (uart.tx_byte_o !== exp) begin
            n_fail++;
            $display("FAIL %s byte %0d: got 0x%02h, required 0x%02h", name, i, uart.tx_byte_o, exp);
         end
         early = 0;
         repeat (3) begin
            @(negedge clk_i);
            if (uart.tx_start_o !== 1'b0) early = 1;
         end
         n_checks++;
         if (early) begin
            n_fail++;
            $display("FAIL %s byte %0d: tx_start_o=1 before tx_complete_i, required 0", name, i);
         end
         uart.tx_complete_i = 1'b1;
         @(negedge clk_i);
         uart.tx_complete_i = 1'b0;
      end
   endtask

   task automatic test_reset();
      int low_cnt, toggles, guard, starts0;
      logic prev;
      starts0 = tx_start_cnt;
      reset_i = 1'b1;
      repeat (3) @(negedge clk_i);
      n_checks += 8;
      if (uart.tx_byte_o !== 8'h00) begin n_fail++; $display("FAIL rst_tx_byte: got %0h, required 0", uart.tx_byte_o); end
      if (uart.tx_start_o !== 1'b0) begin n_fail++; $display("FAIL rst_tx_start: got %0b, required 0", uart.tx_start_o); end
      if (cpu_clk_o !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_clk: got %0b, required 0", cpu_clk_o); end
      if (cpu_reset_n_o !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_reset_n: got %0b, required 0", cpu_reset_n_o); end
      if (last_cmd_o !== 8'h00) begin n_fail++; $display("FAIL rst_last_cmd: got %0h, required 0", last_cmd_o); end
      if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %0b, required 1", busy_o); end
      if (rx_drop_o !== 1'b0) begin n_fail++; $display("FAIL rst_rx_drop: got %0b, required 0", rx_drop_o); end
      if (state_o !== 4'd0) begin n_fail++; $display("FAIL rst_state: got %0d, required 0 (BOOT_HOLD)", state_o); end
      reset_i = 1'b0;
      low_cnt = 0; toggles = 0; guard = 0;
      prev = cpu_clk_o;
      while (cpu_reset_n_o === 1'b0 && guard < 100) begin
         low_cnt++;
         if (cpu_clk_o !== prev) toggles++;
         prev = cpu_clk_o;
         @(negedge clk_i);
         guard++;
      end
      n_checks += 6;
      if (low_cnt != 16) begin n_fail++; $display("FAIL boot_low_cycles: got %0d, required 16", low_cnt); end
      if (toggles != 15) begin n_fail++; $display("FAIL boot_clk_toggles: got %0d, required 15", toggles); end
      if (cpu_clk_o !== 1'b0) begin n_fail++; $display("FAIL boot_clk_end: got %0b, required 0", cpu_clk_o); end
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL boot_busy_end: got %0b, required 0", busy_o); end
      if (state_o !== 4'd1) begin n_fail++; $display("FAIL boot_state_end: got %0d, required 1 (IDLE)", state_o); end
      if (tx_start_cnt != starts0) begin n_fail++; $display("FAIL boot_no_tx: got %0d starts, required 0", tx_start_cnt - starts0); end
   endtask

   task automatic test_single_step();
      int e0;
      e0 = edge_cnt;
      send_rx(8'h63);
      n_checks += 2;
      if (cpu_clk_o !== 1'b1) begin n_fail++; $display("FAIL step_high: got %0b, required 1", cpu_clk_o); end
      @(negedge clk_i);
      if (cpu_clk_o !== 1'b0) begin n_fail++; $display("FAIL step_low_after_1: got %0b, required 0", cpu_clk_o); end
      push_ack(8'h43, 8'h74);
      recv_bytes("ack_Ct", 4);
      n_checks += 3;
      if (edge_cnt - e0 != 1) begin n_fail++; $display("FAIL step_edges: got %0d, required 1", edge_cnt - e0); end
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL step_busy_end: got %0b, required 0", busy_o); end
      if (last_cmd_o !== 8'h63) begin n_fail++; $display("FAIL step_last_cmd: got %0h, required 63", last_cmd_o); end
   endtask

   task automatic test_commands();
      send_rx(8'h65);
      push_ack(8'h52, 8'h61);
      recv_bytes("ack_Ra1", 4);
      n_checks++;
      if (cpu_reset_n_o !== 1'b0) begin n_fail++; $display("FAIL cmd_e_invert: got %0b, required 0", cpu_reset_n_o); end
      send_rx(8'h65);
      push_ack(8'h52, 8'h61);
      recv_bytes("ack_Ra2", 4);
      n_checks++;
      if (cpu_reset_n_o !== 1'b1) begin n_fail++; $display("FAIL cmd_e_restore: got %0b, required 1", cpu_reset_n_o); end
      send_rx(8'h7A);
      push_ack(8'h43, 8'h72);
      recv_bytes("ack_Cr", 4);
      n_checks++;
      if (cpu_clk_o !== 1'b1) begin n_fail++; $display("FAIL cmd_z_clk: got %0b, required 1", cpu_clk_o); end
      send_rx(8'h78);
      push_ack(8'h43, 8'h66);
      recv_bytes("ack_Cf", 4);
      n_checks++;
      if (cpu_clk_o !== 1'b0) begin n_fail++; $display("FAIL cmd_x_clk: got %0b, required 0", cpu_clk_o); end
      send_rx(8'h71);
      push_ack(8'h4F, 8'h6B);
      recv_bytes("ack_Ok", 4);
      n_checks++;
      if (last_cmd_o !== 8'h71) begin n_fail++; $display("FAIL cmd_other_last: got %0h, required 71", last_cmd_o); end
      send_rx(8'h72);
      n_checks++;
      if (cpu_reset_n_o !== 1'b0) begin n_fail++; $display("FAIL cmd_r_hold: got %0b, required 0", cpu_reset_n_o); end
      push_ack(8'h52, 8'h73);
      recv_bytes("ack_Rs", 4);
      n_checks += 2;
      if (cpu_reset_n_o !== 1'b1) begin n_fail++; $display("FAIL cmd_r_release: got %0b, required 1", cpu_reset_n_o); end
      if (cpu_clk_o !== 1'b0) begin n_fail++; $display("FAIL cmd_r_clk: got %0b, required 0", cpu_clk_o); end
   endtask

   task automatic test_stray_complete();
      int s0;
      s0 = tx_start_cnt;
      uart.tx_complete_i = 1'b1;
      @(negedge clk_i);
      uart.tx_complete_i = 1'b0;
      repeat (3) @(negedge clk_i);
      n_checks += 2;
      if (state_o !== 4'd1) begin n_fail++; $display("FAIL stray_state: got %0d, required 1", state_o); end
      if (tx_start_cnt != s0) begin n_fail++; $display("FAIL stray_tx: got %0d starts, required 0", tx_start_cnt - s0); end
   endtask

   task automatic push_dump();
      exp_q.push_back(8'h67); exp_q.push_back(8'h45); exp_q.push_back(8'h23); exp_q.push_back(8'h01);
      exp_q.push_back(8'hEF); exp_q.push_back(8'hCD); exp_q.push_back(8'hAB); exp_q.push_back(8'h89);
`ifdef DBG_CHECKSUM_EN
      exp_q.push_back(8'h00);
`endif
   endtask

   task automatic test_status_dump();
      int n;
      status_i = 64'h89ABCDEF_01234567;
      send_rx(8'h73);
      @(negedge clk_i);
      status_i = 64'h5555AAAA_F00DBEEF;
      push_dump();
      n = exp_q.size();
      recv_bytes("dump", n);
      repeat (5) @(negedge clk_i);
      n_checks += 2;
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL dump_busy_end: got %0b, required 0", busy_o); end
      if (uart.tx_start_o !== 1'b0) begin n_fail++; $display("FAIL dump_no_ack: got %0b, required 0", uart.tx_start_o); end
   endtask

   task automatic test_burst_full();
      int e0, s0;
      e0 = edge_cnt; s0 = spacing_err;
      burst_mon = 1;
      send_rx(8'h6E);
      push_ack(8'h43, 8'h6E);
      recv_bytes("ack_Cn", 4);
      burst_mon = 0;
      n_checks += 3;
      if (edge_cnt - e0 != 256) begin n_fail++; $display("FAIL burst_edges: got %0d, required 256", edge_cnt - e0); end
      if (spacing_err != s0) begin n_fail++; $display("FAIL burst_spacing: got %0d bad gaps, required 0", spacing_err - s0); end
      if (cpu_clk_o !== 1'b0) begin n_fail++; $display("FAIL burst_clk_end: got %0b, required 0", cpu_clk_o); end
   endtask

   task automatic test_burst_halt();
      int e0, g, d;
      e0 = edge_cnt;
      send_rx(8'h6E);
      g = 0;
      while (edge_cnt - e0 < 10 && g < 200) begin
         @(negedge clk_i);
         g++;
      end
      halt_i = 1'b1;
      push_ack(8'h43, 8'h68);
      recv_bytes("ack_Ch", 4);
      d = edge_cnt - e0;
      n_checks += 2;
      if (d != 10 && d != 11) begin n_fail++; $display("FAIL halt_edges: got %0d, required 10 or 11", d); end
      if (cpu_clk_o !== 1'b0) begin n_fail++; $display("FAIL halt_clk_end: got %0b, required 0", cpu_clk_o); end
      e0 = edge_cnt;
      send_rx(8'h6E);
      push_ack(8'h43, 8'h68);
      recv_bytes("ack_Ch_entry", 4);
      n_checks++;
      if (edge_cnt != e0) begin n_fail++; $display("FAIL halt_entry_edges: got %0d, required 0", edge_cnt - e0); end
      halt_i = 1'b0;
   endtask

   task automatic test_drop_mid_dump();
      int n;
      status_i = 64'h89ABCDEF_01234567;
      send_rx(8'h73);
      @(negedge clk_i);
      status_i = 64'h11223344_55667788;
      push_dump();
      n = exp_q.size();
      recv_bytes("drop_dump_head", 2);
      send_rx(8'h71);
      n_checks += 2;
      if (rx_drop_o !== 1'b1) begin n_fail++; $display("FAIL drop_flag: got %0b, required 1", rx_drop_o); end
      if (last_cmd_o !== 8'h73) begin n_fail++; $display("FAIL drop_last_cmd: got %0h, required 73", last_cmd_o); end
      recv_bytes("drop_dump_tail", n - 2);
      repeat (5) @(negedge clk_i);
      n_checks += 2;
      if (busy_o !== 1'b0) begin n_fail++; $display("FAIL drop_busy_end: got %0b, required 0", busy_o); end
      if (rx_drop_o !== 1'b1) begin n_fail++; $display("FAIL drop_sticky: got %0b, required 1", rx_drop_o); end
   endtask

   task automatic test_reset_mid_dump();
      int s0;
      status_i = 64'h89ABCDEF_01234567;
      send_rx(8'h73);
      push_dump();
      recv_bytes("abort_dump_head", 3);
      exp_q.delete();
      s0 = tx_start_cnt;
      test_reset();
      repeat (20) @(negedge clk_i);
      n_checks++;
      if (tx_start_cnt != s0) begin n_fail++; $display("FAIL abort_no_tx: got %0d starts, required 0", tx_start_cnt - s0); end
   endtask

   initial begin
      test_reset();
      test_single_step();
      test_commands();
      test_stray_complete();
      test_status_dump();
      test_burst_full();
      test_burst_halt();
      test_drop_mid_dump();
      test_reset_mid_dump();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
